// File: rtl/hex_sched_pkg.sv
// Shared types and helpers for the hex target scheduler.
// States, value width, the reserved zero value and the forced-value wrap rule.
package hex_sched_pkg;

    localparam int VALUE_W = 8;
    localparam logic [VALUE_W-1:0] ZERO_VALUE = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    // Successor of v that never lands on zero: 0xFF wraps to 0x01.
    function automatic logic [VALUE_W-1:0] next_nonzero(input logic [VALUE_W-1:0] v);
        logic [VALUE_W-1:0] n;
        n = v + VALUE_W'(1);
        return (n == ZERO_VALUE) ? VALUE_W'(1) : n;
    endfunction

endpackage

// File: rtl/hex_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
// Produces a one-hot winner and its index; both are zero when req is empty.
module hex_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx
);

    logic             found;
    logic [IDX_W-1:0] sel;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        sel     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sel = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[sel]) begin
                found    = 1'b1;
                win[sel] = 1'b1;
                win_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/hex_target_sched.sv
// Round-robin scheduler handing out nonzero LFSR bytes to NUM_REQ requesters.
// Define HEX_SCHED_NODUP_EN to also reject a draw equal to the previous issued value.
module hex_target_sched
    import hex_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_RETRY = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [VALUE_W-1:0]   rnd_in,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [VALUE_W-1:0]   value,
    output logic                 busy,
    output logic                 forced
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [7:0] RTY_LAST = 8'(MAX_RETRY - 1);

    state_t               state;
    logic [IDX_W-1:0]     cur;
    logic [NUM_REQ-1:0]   cur_oh;
    logic [IDX_W-1:0]     rr_ptr;
    logic [7:0]           retry_cnt;
    logic [VALUE_W-1:0]   last_value;
    logic [NUM_REQ-1:0]   arb_win;
    logic [IDX_W-1:0]     arb_idx;
    logic                 reject;

    hex_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .win     (arb_win),
        .win_idx (arb_idx)
    );

`ifdef HEX_SCHED_NODUP_EN
    assign reject = (rnd_in == ZERO_VALUE) || (rnd_in == last_value);
`else
    assign reject = (rnd_in == ZERO_VALUE);
`endif

    // rr_ptr holds the last granted index; NUM_REQ-1 at reset puts requester 0 first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cur        <= '0;
            cur_oh     <= '0;
            rr_ptr     <= IDX_W'(NUM_REQ - 1);
            retry_cnt  <= '0;
            last_value <= ZERO_VALUE;
            gnt        <= '0;
            value      <= ZERO_VALUE;
            busy       <= 1'b0;
            forced     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gnt <= '0;
                    if (|req) begin
                        cur       <= arb_idx;
                        cur_oh    <= arb_win;
                        retry_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= DRAW;
                    end
                end
                DRAW: begin
                    if (!req[cur]) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!reject) begin
                        value  <= rnd_in;
                        forced <= 1'b0;
                        gnt    <= cur_oh;
                        state  <= ISSUE;
                    end else if (retry_cnt == RTY_LAST) begin
                        value  <= next_nonzero(last_value);
                        forced <= 1'b1;
                        gnt    <= cur_oh;
                        state  <= ISSUE;
                    end else begin
                        retry_cnt <= retry_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    gnt        <= '0;
                    last_value <= value;
                    rr_ptr     <= cur;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_target_sched.sv
// Directed bench for hex_target_sched: latency, round-robin order, forced path,
// dedup behaviour (follows HEX_SCHED_NODUP_EN), abort and async reset.
module tb_hex_target_sched;

    logic       clk;
    logic       rst;
    logic [7:0] rnd_in;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] value;
    logic       busy;
    logic       forced;

    int n_chk;
    int n_fail;

    logic [3:0] g;
    int         n;
    int         nb;
    int         e;
    int         k;
    int         last_e;
    logic [3:0] exp_g;

    hex_target_sched #(
        .NUM_REQ   (4),
        .MAX_RETRY (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rnd_in (rnd_in),
        .req    (req),
        .gnt    (gnt),
        .value  (value),
        .busy   (busy),
        .forced (forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        rnd_in = 8'h00;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Raise r, wait for a grant (bounded), drop the granted bit, return to IDLE.
    // rnd_in is r0, switching to r1 after edge number sw (sw=0: never).
    task automatic do_grant(input logic [3:0] r, input logic [7:0] r0, input int sw,
                            input logic [7:0] r1, output logic [3:0] go,
                            output int nout, output int nbusy);
        int seen;
        seen  = 0;
        go    = '0;
        nout  = 0;
        nbusy = 0;
        req    = r;
        rnd_in = r0;
        for (int i = 1; i <= 40 && seen == 0; i++) begin
            tick();
            if (busy) nbusy++;
            if (sw != 0 && i == sw) rnd_in = r1;
            if (gnt != 0) begin
                seen = 1;
                go   = gnt;
                nout = i;
            end
        end
        chk("gnt_seen", seen, 1);
        req = req & ~go;
        tick();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        req    = '0;
        rnd_in = 8'h00;
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_value", value, 0);
        chk("rst_busy", busy, 0);
        chk("rst_forced", forced, 0);
        do_reset();

        // best-case single grant
        do_grant(4'b0001, 8'h3A, 0, 8'h00, g, n, nb);
        chk("basic_gnt", g, 4'b0001);
        chk("basic_lat", n, 2);
        chk("basic_busy", nb, 2);
        chk("basic_value", value, 8'h3A);
        chk("basic_forced", forced, 0);
        chk("basic_gnt_off", gnt, 0);
        chk("basic_busy_off", busy, 0);

        // all four requesting from reset priority: 0,1,2,3 every 3 cycles
        do_reset();
        req    = 4'b1111;
        e      = 0;
        k      = 0;
        last_e = 0;
        while (k < 4 && e < 60) begin
            rnd_in = 8'h20 + 8'(e);
            tick();
            e++;
            if (gnt != 0) begin
                exp_g = 4'(1 << k);
                chk("rr_order", gnt, exp_g);
                if (k > 0) chk("rr_gap", e - last_e, 3);
                last_e = e;
                req = req & ~gnt;
                k++;
            end
        end
        chk("rr_count", k, 4);
        tick();

        // forced path: last 0xFF, all-zero draws -> 0x01 after 9 cycles
        do_grant(4'b0001, 8'hFF, 0, 8'h00, g, n, nb);
        chk("pre_ff_value", value, 8'hFF);
        do_grant(4'b0010, 8'h00, 0, 8'h00, g, n, nb);
        chk("forced_gnt", g, 4'b0010);
        chk("forced_lat", n, 9);
        chk("forced_value", value, 8'h01);
        chk("forced_flag", forced, 1);

        // repeat of previous value
        do_grant(4'b0001, 8'h5C, 0, 8'h00, g, n, nb);
        chk("pre_5c_forced", forced, 0);
        do_grant(4'b1000, 8'h5C, 3, 8'h71, g, n, nb);
        chk("dup_gnt", g, 4'b1000);
`ifdef HEX_SCHED_NODUP_EN
        chk("dup_lat", n, 4);
        chk("dup_value", value, 8'h71);
`else
        chk("dup_lat", n, 2);
        chk("dup_value", value, 8'h5C);
`endif
        chk("dup_forced", forced, 0);

        // abort: req[2] dropped mid-draw
        req    = 4'b0100;
        rnd_in = 8'h00;
        tick();
        tick();
        chk("abort_busy_draw", busy, 1);
        req = 4'b0000;
        tick();
        chk("abort_busy_off", busy, 0);
        chk("abort_no_gnt", gnt, 0);
        tick();
        tick();
        chk("abort_still_no_gnt", gnt, 0);
        do_grant(4'b1000, 8'h42, 0, 8'h00, g, n, nb);
        chk("after_abort_gnt", g, 4'b1000);
        chk("after_abort_lat", n, 2);
        chk("after_abort_value", value, 8'h42);

        // grant requester 1 so the pointer is away from its reset position
        do_grant(4'b0010, 8'h55, 0, 8'h00, g, n, nb);
        chk("pre_rst_gnt", g, 4'b0010);

        // async reset while in DRAW
        req    = 4'b0001;
        rnd_in = 8'h00;
        tick();
        tick();
        chk("mid_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_value", value, 0);
        chk("async_gnt", gnt, 0);
        chk("async_forced", forced, 0);
        req = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_gnt", gnt, 0);
        do_grant(4'b1001, 8'h66, 0, 8'h00, g, n, nb);
        chk("post_rst_prio", g, 4'b0001);
        do_grant(4'b0010, 8'h3B, 0, 8'h00, g, n, nb);
        chk("post_rst_gnt1", g, 4'b0010);
        chk("post_rst_value", value, 8'h3B);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
